// File: rtl/polynomial_tile_sequencer_pkg.sv
// Shared definitions for the tiled polynomial multiplier: coefficient type,
// default geometry and the helper functions that derive tile counts and
// index/offset widths. The output loader imports this package as well.
package poly_mult_pkg;

  localparam int DEFAULT_DATA_WIDTH        = 16;
  localparam int DEFAULT_POLY_A_WIDTH      = 27;
  localparam int DEFAULT_POLY_B_WIDTH      = 27;
  localparam int DEFAULT_POLY_A_TILE_WIDTH = 3;
  localparam int DEFAULT_POLY_B_TILE_WIDTH = 9;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] coeff_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_DONE
  } seq_state_t;

  // Number of tiles a polynomial splits into.
  function automatic int num_tiles(input int width, input int tile_width);
    return width / tile_width;
  endfunction

  // Bits needed to hold a tile index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to address any coefficient of the product polynomial C.
  function automatic int offset_width(input int a_width, input int b_width);
    return $clog2(a_width + b_width - 1);
  endfunction

endpackage

// File: rtl/polynomial_tile_sequencer_if.sv
// Tile handshake bus between the sequencer (master) and the multiplier
// array / adder tree (slave).
interface polynomial_tile_sequencer_if
  import poly_mult_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int A_TILE_WIDTH = DEFAULT_POLY_A_TILE_WIDTH,
  parameter int B_TILE_WIDTH = DEFAULT_POLY_B_TILE_WIDTH,
  parameter int A_IDX_W      = 4,
  parameter int B_IDX_W      = 2,
  parameter int OFF_W        = 6
);

  logic                                   tile_valid;
  logic                                   tile_accept;
  logic [A_TILE_WIDTH-1:0][DATA_WIDTH-1:0] a_tile;
  logic [B_TILE_WIDTH-1:0][DATA_WIDTH-1:0] b_tile;
  logic [A_IDX_W-1:0]                     a_idx;
  logic [B_IDX_W-1:0]                     b_idx;
  logic [OFF_W-1:0]                       c_offset;
  logic                                   last_tile;

  modport master (
    output tile_valid, a_tile, b_tile, a_idx, b_idx, c_offset, last_tile,
    input  tile_accept
  );

  modport slave (
    input  tile_valid, a_tile, b_tile, a_idx, b_idx, c_offset, last_tile,
    output tile_accept
  );

endinterface

// File: rtl/polynomial_tile_sequencer_tile_index_counter.sv
// Nested tile index counter: a_idx is the inner loop, b_idx advances each
// time a_idx wraps. last flags the final (NA-1, NB-1) pair.
module tile_index_counter #(
  parameter int NA = 9,
  parameter int NB = 3,
  parameter int AW = 4,
  parameter int BW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [AW-1:0] a_idx,
  output logic [BW-1:0] b_idx,
  output logic          last
);

  localparam logic [AW-1:0] A_MAX = AW'(NA - 1);
  localparam logic [BW-1:0] B_MAX = BW'(NB - 1);

  assign last = (a_idx == A_MAX) && (b_idx == B_MAX);

  // Advance the pair on each enable; clear restarts at the first pair.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values and a_idx/b_idx update together without ordering races.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      a_idx <= '0;
      b_idx <= '0;
    end else if (enable) begin
      if (a_idx == A_MAX) begin
        a_idx <= '0;
        b_idx <= (b_idx == B_MAX) ? '0 : b_idx + 1'b1;
      end else begin
        a_idx <= a_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/polynomial_tile_sequencer.sv
// Latches operands A and B on start, then presents every (A-tile, B-tile)
// pair with its indices and C offset on a valid/accept handshake.
module polynomial_tile_sequencer
  import poly_mult_pkg::*;
#(
  parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
  parameter int POLY_A_WIDTH      = DEFAULT_POLY_A_WIDTH,
  parameter int POLY_B_WIDTH      = DEFAULT_POLY_B_WIDTH,
  parameter int POLY_A_TILE_WIDTH = DEFAULT_POLY_A_TILE_WIDTH,
  parameter int POLY_B_TILE_WIDTH = DEFAULT_POLY_B_TILE_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [POLY_A_WIDTH-1:0][DATA_WIDTH-1:0] poly_a,
  input  logic [POLY_B_WIDTH-1:0][DATA_WIDTH-1:0] poly_b,
  polynomial_tile_sequencer_if.master             tile_bus,
  output logic                                   busy,
  output logic                                   done
);

  localparam int NA      = num_tiles(POLY_A_WIDTH, POLY_A_TILE_WIDTH);
  localparam int NB      = num_tiles(POLY_B_WIDTH, POLY_B_TILE_WIDTH);
  localparam int A_IDX_W = idx_width(NA);
  localparam int B_IDX_W = idx_width(NB);
  localparam int OFF_W   = offset_width(POLY_A_WIDTH, POLY_B_WIDTH);

  if (POLY_A_WIDTH % POLY_A_TILE_WIDTH != 0) begin : g_bad_a_tile
    $error("POLY_A_TILE_WIDTH must divide POLY_A_WIDTH");
  end
  if (POLY_B_WIDTH % POLY_B_TILE_WIDTH != 0) begin : g_bad_b_tile
    $error("POLY_B_TILE_WIDTH must divide POLY_B_WIDTH");
  end

  seq_state_t                             state;
  logic                                   tile_valid_q;
  logic [POLY_A_WIDTH-1:0][DATA_WIDTH-1:0] a_reg;
  logic [POLY_B_WIDTH-1:0][DATA_WIDTH-1:0] b_reg;
  logic [A_IDX_W-1:0]                     a_idx;
  logic [B_IDX_W-1:0]                     b_idx;
  logic                                   cnt_last;
  logic                                   cnt_clear;
  logic                                   cnt_enable;
  int                                     a_base;
  int                                     b_base;

  assign cnt_clear  = (state == SEQ_IDLE) && start;
  assign cnt_enable = tile_valid_q && tile_bus.tile_accept;

  tile_index_counter #(
    .NA (NA),
    .NB (NB),
    .AW (A_IDX_W),
    .BW (B_IDX_W)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .a_idx  (a_idx),
    .b_idx  (b_idx),
    .last   (cnt_last)
  );

  // Coefficient base of the current tiles; also the two halves of c_offset.
  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    a_base = int'(a_idx) * POLY_A_TILE_WIDTH;
    b_base = int'(b_idx) * POLY_B_TILE_WIDTH;
  end

  // Tile data and offset come straight from registered state, so they hold
  // still for as long as the downstream stalls.
  assign tile_bus.tile_valid = tile_valid_q;
  assign tile_bus.a_tile     = a_reg[a_base +: POLY_A_TILE_WIDTH];
  assign tile_bus.b_tile     = b_reg[b_base +: POLY_B_TILE_WIDTH];
  assign tile_bus.a_idx      = a_idx;
  assign tile_bus.b_idx      = b_idx;
  assign tile_bus.c_offset   = OFF_W'(a_base + b_base);
  assign tile_bus.last_tile  = tile_valid_q && cnt_last;

  // Sequencing FSM: latch operands, issue all tile pairs, pulse done.
  // NOTE: the operand registers are cleared on reset even though they are
  // wide; the tile outputs slice them directly and must read zero in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEQ_IDLE;
      tile_valid_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
    end else begin
      unique case (state)
        SEQ_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg        <= poly_a;
            b_reg        <= poly_b;
            tile_valid_q <= 1'b1;
            busy         <= 1'b1;
            state        <= SEQ_ISSUE;
          end
        end
        SEQ_ISSUE: begin
          if (cnt_enable && cnt_last) begin
            tile_valid_q <= 1'b0;
            done         <= 1'b1;
            state        <= SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= SEQ_IDLE;
        end
        default: begin
          tile_valid_q <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
          state        <= SEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_polynomial_tile_sequencer.sv
// Scoreboard bench for polynomial_tile_sequencer: the stimulus side pushes
// the expected tile stream computed from the operands, a monitor pops and
// compares on every accepted tile and tracks the done pulse.
module tb_polynomial_tile_sequencer;
  import poly_mult_pkg::*;

  localparam int DW    = 16;
  localparam int PA    = 27;
  localparam int PB    = 27;
  localparam int TA    = 3;
  localparam int TB    = 9;
  localparam int NA    = PA / TA;
  localparam int NB    = PB / TB;
  localparam int TOTAL = NA * NB;
  localparam int AW    = 4;
  localparam int BW    = 2;
  localparam int OW    = 6;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [PA-1:0][DW-1:0]  poly_a;
  logic [PB-1:0][DW-1:0]  poly_b;
  logic                   busy;
  logic                   done;

  polynomial_tile_sequencer_if #(
    .DATA_WIDTH   (DW),
    .A_TILE_WIDTH (TA),
    .B_TILE_WIDTH (TB),
    .A_IDX_W      (AW),
    .B_IDX_W      (BW),
    .OFF_W        (OW)
  ) tile_bus ();

  polynomial_tile_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .poly_a   (poly_a),
    .poly_b   (poly_b),
    .tile_bus (tile_bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TA*DW-1:0] a;
    logic [TB*DW-1:0] b;
    int               ai;
    int               bi;
    int               off;
    bit               last;
  } tile_t;

  tile_t  exp_q[$];
  coeff_t ref_a[PA];
  coeff_t ref_b[PB];
  int     n_checks = 0;
  int     n_fail   = 0;
  bit     done_due = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: B tiles form the outer loop, A tiles the inner loop;
  // each pair covers C coefficients starting at ai*TA + bi*TB.
  task automatic push_expected();
    tile_t e;
    for (int bi = 0; bi < NB; bi++) begin
      for (int ai = 0; ai < NA; ai++) begin
        for (int k = 0; k < TA; k++) e.a[k*DW +: DW] = ref_a[ai*TA + k];
        for (int k = 0; k < TB; k++) e.b[k*DW +: DW] = ref_b[bi*TB + k];
        e.ai   = ai;
        e.bi   = bi;
        e.off  = ai * TA + bi * TB;
        e.last = (ai == NA - 1) && (bi == NB - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // mode 0: A[i] = i+1, B all ones; otherwise random coefficients.
  task automatic load_operands(input int mode);
    for (int i = 0; i < PA; i++) ref_a[i] = (mode == 0) ? coeff_t'(i + 1) : coeff_t'($urandom);
    for (int i = 0; i < PB; i++) ref_b[i] = (mode == 0) ? coeff_t'(1) : coeff_t'($urandom);
    for (int i = 0; i < PA; i++) poly_a[i] = ref_a[i];
    for (int i = 0; i < PB; i++) poly_b[i] = ref_b[i];
  endtask

  // Called just after a rising edge while IDLE; leaves off just after the
  // edge that samples start.
  task automatic start_seq();
    check("idle_before_start_valid", tile_bus.tile_valid, 1'b0);
    push_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("first_tile_latency", tile_bus.tile_valid, 1'b1);
    check("busy_after_start", busy, 1'b1);
  endtask

  // Drive tile_accept until stop_at tiles (or all) are accepted. Optional
  // 5-cycle stall when stall_at tiles are done, random backpressure, and an
  // operand change plus start pulse when poke_at tiles are done.
  task automatic run_tiles(input int stall_at, input bit rand_bp, input int poke_at, input int stop_at);
    int   acc = 0;
    int   cyc = 0;
    int   stall_left = 5;
    int   limit;
    bit   hs;
    bit   stalling;
    bit   poked = 1'b0;
    logic acc_bit;
    limit = (stop_at >= 0) ? stop_at : TOTAL;
    while (acc < limit && cyc < 2000) begin
      acc_bit  = 1'b1;
      stalling = 1'b0;
      if (rand_bp) acc_bit = ($urandom_range(0, 3) != 0);
      if (acc == stall_at && stall_left > 0) begin
        acc_bit  = 1'b0;
        stalling = 1'b1;
        stall_left--;
      end
      tile_accept_drv = acc_bit;
      start = 1'b0;
      if (acc == poke_at && !poked) begin
        poked = 1'b1;
        for (int i = 0; i < PA; i++) poly_a[i] = coeff_t'($urandom);
        for (int i = 0; i < PB; i++) poly_b[i] = coeff_t'($urandom);
        start = 1'b1;
      end
      @(negedge clk);
      if (stalling) begin
        if (exp_q.size() == 0) fail_now("stall_no_expected_tile");
        else begin
          check("stall_valid", tile_bus.tile_valid, 1'b1);
          check("stall_a_tile", tile_bus.a_tile, exp_q[0].a);
          check("stall_b_tile", tile_bus.b_tile, exp_q[0].b);
          check("stall_a_idx", tile_bus.a_idx, exp_q[0].ai);
          check("stall_c_offset", tile_bus.c_offset, exp_q[0].off);
        end
      end
      hs = tile_bus.tile_valid && tile_bus.tile_accept;
      @(posedge clk); #1;
      if (hs) acc++;
      cyc++;
    end
    start = 1'b0;
    tile_accept_drv = 1'b0;
    if (acc < limit) fail_now("tile_timeout");
  endtask

  // Called in the done cycle; optionally pulses start there (must be ignored).
  task automatic finish_seq(input bit poke_start);
    if (poke_start) begin
      for (int i = 0; i < PA; i++) poly_a[i] = coeff_t'($urandom);
      start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_valid_after_done", tile_bus.tile_valid, 1'b0);
    check("idle_busy_after_done", busy, 1'b0);
    check("idle_done_after_done", done, 1'b0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  logic tile_accept_drv = 1'b0;
  assign tile_bus.tile_accept = tile_accept_drv;

  // Monitor: compare every accepted tile with the head of the scoreboard and
  // require done exactly one cycle after the final accept.
  always @(negedge clk) begin
    tile_t e;
    if (rst) begin
      done_due = 1'b0;
    end else begin
      check("done_pulse", done, done_due);
      if (done_due) check("busy_during_done", busy, 1'b1);
      done_due = 1'b0;
      if (tile_bus.tile_valid && tile_bus.tile_accept) begin
        if (exp_q.size() == 0) fail_now("unexpected_tile");
        else begin
          e = exp_q.pop_front();
          check("a_tile", tile_bus.a_tile, e.a);
          check("b_tile", tile_bus.b_tile, e.b);
          check("a_idx", tile_bus.a_idx, e.ai);
          check("b_idx", tile_bus.b_idx, e.bi);
          check("c_offset", tile_bus.c_offset, e.off);
          check("last_tile", tile_bus.last_tile, e.last);
          check("busy_while_issuing", busy, 1'b1);
          if (e.last) done_due = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    poly_a = '0;
    poly_b = '0;
    // Reset held three cycles, then idle with a stray accept.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tile_accept_drv = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset_tile_valid", tile_bus.tile_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_a_idx", tile_bus.a_idx, 0);
      check("reset_b_idx", tile_bus.b_idx, 0);
      check("reset_c_offset", tile_bus.c_offset, 0);
      check("reset_last_tile", tile_bus.last_tile, 1'b0);
    end
    @(posedge clk); #1;
    tile_accept_drv = 1'b0;

    // Basic ordering with accept held high; start during DONE is ignored.
    load_operands(0);
    start_seq();
    run_tiles(-1, 1'b0, -1, -1);
    finish_seq(1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: five-cycle stall on the fourth tile.
    load_operands(1);
    start_seq();
    run_tiles(3, 1'b0, -1, -1);
    finish_seq(1'b0);

    // Restart in the cycle right after done, with operand change and start
    // pulse mid-sequence under random backpressure.
    load_operands(1);
    start_seq();
    run_tiles(-1, 1'b1, 5, -1);
    finish_seq(1'b0);

    // Mid-sequence reset while tile 12 is presented.
    load_operands(1);
    start_seq();
    run_tiles(-1, 1'b0, -1, 11);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_tile_valid", tile_bus.tile_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_a_idx", tile_bus.a_idx, 0);
    check("abort_b_idx", tile_bus.b_idx, 0);
    check("abort_c_offset", tile_bus.c_offset, 0);
    check("abort_a_tile", tile_bus.a_tile, 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done, 1'b0);
    @(posedge clk); #1;
    load_operands(1);
    start_seq();
    run_tiles(-1, 1'b1, -1, -1);
    finish_seq(1'b0);

    // A couple more random sequences with random backpressure.
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      load_operands(1);
      start_seq();
      run_tiles(-1, 1'b1, -1, -1);
      finish_seq(1'b0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
